// File: rtl/ldpc_3gpp_enc_buf_ctrl.sv
// Bank buffer controller between the LDPC encoder write side and the encoder engine.
// Optional sticky overflow output oovf is built when LDPC_3GPP_ENC_BUF_CTRL_OVF_EN is defined.
module ldpc_3gpp_enc_buf_ctrl #(
    parameter int pADDR_W = 8,
    parameter int pBNUM_W = 1
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               iwfull,
    input  logic [pADDR_W-1:0] iwaddr,
    output logic [pBNUM_W-1:0] owbank,
    output logic               ofulla,
    output logic               oemptya,
    output logic [pBNUM_W:0]   ocnt,
    input  logic               irbusy,
    input  logic               irdone,
    output logic               ostart,
    output logic [pBNUM_W-1:0] orbank,
    output logic [pADDR_W-1:0] olen
`ifdef LDPC_3GPP_ENC_BUF_CTRL_OVF_EN
    ,
    output logic               oovf
`endif
);

    localparam int cN = 2**pBNUM_W;
    localparam logic [pBNUM_W:0] cFULL = {1'b1, {pBNUM_W{1'b0}}};

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    state_t             nstate;
    logic [pADDR_W-1:0] len [cN];
    logic               wr_acc;
    logic               rd_start;
    logic               rd_ret;

    assign ofulla  = (ocnt == cFULL);
    assign oemptya = (ocnt == '0);
    assign wr_acc  = iwfull && !ofulla;

    // The bank under read stays counted in ocnt until the engine reports done.
    always_comb begin
        nstate   = state;
        rd_start = 1'b0;
        rd_ret   = 1'b0;
        case (state)
            IDLE: begin
                if (!oemptya && !irbusy) begin
                    rd_start = 1'b1;
                    nstate   = BUSY;
                end
            end
            BUSY: begin
                if (irdone) begin
                    rd_ret = 1'b1;
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state <= IDLE;
        end else if (iclkena) begin
            state <= nstate;
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            owbank <= '0;
            orbank <= '0;
            ocnt   <= '0;
            ostart <= 1'b0;
            olen   <= '0;
        end else if (iclkena) begin
            ostart <= rd_start;
            if (wr_acc) begin
                owbank <= owbank + 1'b1;
            end
            if (rd_ret) begin
                orbank <= orbank + 1'b1;
            end
            if (wr_acc && !rd_ret) begin
                ocnt <= ocnt + 1'b1;
            end else if (!wr_acc && rd_ret) begin
                ocnt <= ocnt - 1'b1;
            end
            if (rd_start) begin
                olen <= len[orbank];
            end
        end
    end

    // Length storage is deliberately not reset; a block is only read after it was written.
    always_ff @(posedge iclk) begin
        if (iclkena && wr_acc) begin
            len[owbank] <= iwaddr;
        end
    end

`ifdef LDPC_3GPP_ENC_BUF_CTRL_OVF_EN
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            oovf <= 1'b0;
        end else if (iclkena && iwfull && ofulla) begin
            oovf <= 1'b1;
        end
    end
`endif

endmodule
